arith_stream_sequencer: RTL

Sequencer on the ram_clock side of the HPS/arith dual-port RAM. Drives the arith port (port B) of the RAM: fetches operand pairs, hands each pair to the downstream online-arithmetic datapath over a valid/ready handshake, and writes each result back into the RAM. Lets the HPS load operand vectors through the Avalon side, pulse start, and read results back without per-element software involvement.

---
 rtl/arith_stream_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/arith_stream_sequencer.sv
// Port-B sequencer for the HPS/arith dual-port RAM: fetches operand pairs, hands them to the
// online-arithmetic datapath over valid/ready, and writes each result back to the RAM.
module arith_stream_sequencer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 11
) (
   input  logic                  ram_clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] count,
   input  logic [ADDR_WIDTH-1:0] base_a,
   input  logic [ADDR_WIDTH-1:0] base_b,
   input  logic [ADDR_WIDTH-1:0] base_r,
   output logic [ADDR_WIDTH-1:0] addr_arith,
   output logic [DATA_WIDTH-1:0] data_arith,
   output logic                  we_arith,
   input  logic [DATA_WIDTH-1:0] q_arith,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [DATA_WIDTH-1:0] op_a,
   output logic [DATA_WIDTH-1:0] op_b,
   input  logic                  res_valid,
   input  logic [DATA_WIDTH-1:0] res_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] elem_idx,
   output logic                  res_unexpected
);

   localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_A     = 3'd1,
      RD_B     = 3'd2,
      CAP_B    = 3'd3,
      ISSUE    = 3'd4,
      WAIT_RES = 3'd5,
      WRITE    = 3'd6,
      DONE     = 3'd7
   } state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] count_q, count_n;
   logic [ADDR_WIDTH-1:0] base_a_q, base_a_n;
   logic [ADDR_WIDTH-1:0] base_b_q, base_b_n;
   logic [ADDR_WIDTH-1:0] base_r_q, base_r_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic                  we_n;
   logic                  op_valid_n;
   logic [DATA_WIDTH-1:0] op_a_n, op_b_n;
   logic                  busy_n, done_n;
   logic [ADDR_WIDTH-1:0] idx_n, idx_inc;
   logic                  unexp_n;

   // State and registered outputs; reset drops we_arith immediately so no partial write occurs.
   always_ff @(posedge ram_clock or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         count_q        <= '0;
         base_a_q       <= '0;
         base_b_q       <= '0;
         base_r_q       <= '0;
         addr_arith     <= '0;
         data_arith     <= '0;
         we_arith       <= 1'b0;
         op_valid       <= 1'b0;
         op_a           <= '0;
         op_b           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         elem_idx       <= '0;
         res_unexpected <= 1'b0;
      end else begin
         state          <= state_n;
         count_q        <= count_n;
         base_a_q       <= base_a_n;
         base_b_q       <= base_b_n;
         base_r_q       <= base_r_n;
         addr_arith     <= addr_n;
         data_arith     <= data_n;
         we_arith       <= we_n;
         op_valid       <= op_valid_n;
         op_a           <= op_a_n;
         op_b           <= op_b_n;
         busy           <= busy_n;
         done           <= done_n;
         elem_idx       <= idx_n;
         res_unexpected <= unexp_n;
      end
   end

   // Next state plus the output values that belong to the state being entered.
   always_comb begin
      state_n    = state;
      count_n    = count_q;
      base_a_n   = base_a_q;
      base_b_n   = base_b_q;
      base_r_n   = base_r_q;
      addr_n     = addr_arith;
      data_n     = data_arith;
      we_n       = 1'b0;
      op_valid_n = op_valid;
      op_a_n     = op_a;
      op_b_n     = op_b;
      busy_n     = busy;
      done_n     = 1'b0;
      idx_n      = elem_idx;
      unexp_n    = res_unexpected;
      idx_inc    = elem_idx + IDX_ONE;

      case (state)
         IDLE: begin
            if (start) begin
               count_n  = count;
               base_a_n = base_a;
               base_b_n = base_b;
               base_r_n = base_r;
               idx_n    = '0;
               unexp_n  = 1'b0;
               if (count == '0) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = RD_A;
                  busy_n  = 1'b1;
                  addr_n  = base_a;
               end
            end
         end
         RD_A: begin
            state_n = RD_B;
            addr_n  = base_b_q + elem_idx;
         end
         RD_B: begin
            state_n = CAP_B;
            op_a_n  = q_arith;
         end
         CAP_B: begin
            state_n    = ISSUE;
            op_b_n     = q_arith;
            op_valid_n = 1'b1;
         end
         ISSUE: begin
            if (op_ready) begin
               state_n    = WAIT_RES;
               op_valid_n = 1'b0;
            end
         end
         WAIT_RES: begin
            if (res_valid) begin
               state_n = WRITE;
               data_n  = res_data;
               addr_n  = base_r_q + elem_idx;
               we_n    = 1'b1;
            end
         end
         WRITE: begin
            idx_n = idx_inc;
            if (idx_inc == count_q) begin
               state_n = DONE;
               done_n  = 1'b1;
               busy_n  = 1'b0;
            end else begin
               state_n = RD_A;
               addr_n  = base_a_q + idx_inc;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // A result strobe outside WAIT_RES is dropped but remembered.
      if (res_valid && (state != WAIT_RES)) begin
         unexp_n = 1'b1;
      end
   end

endmodule
